// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, hold
// timeout and a forced idle cycle between consecutive grants.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic       GNT_VALID,
    output logic       TIMEOUT_ERR,
    output logic [0:0] o_dbg_state,
    output logic [1:0] o_dbg_ptr
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic             TO_EN     = (MAX_HOLD != 0);

    logic [0:0]       r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_id;
    logic             r_gnt_valid;
    logic             r_timeout_err;

    logic [1:0] w_win;
    logic       w_found;
    logic       w_rel_normal;
    logic       w_rel_timeout;

    // Search from the pointer upward (mod 4); the first active request wins.
    always_comb begin
        w_win   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && REQ[r_ptr + 2'(k)]) begin
                w_win   = r_ptr + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_rel_normal  = DONE || !REQ[r_gnt_id];
    assign w_rel_timeout = !w_rel_normal && TO_EN && (r_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 2'd0;
            r_cnt         <= '0;
            r_gnt         <= 4'b0000;
            r_gnt_id      <= 2'd0;
            r_gnt_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt       <= 4'b0001 << w_win;
                        r_gnt_id    <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_rel_normal || w_rel_timeout) begin
                        r_gnt         <= 4'b0000;
                        r_gnt_id      <= 2'd0;
                        r_gnt_valid   <= 1'b0;
                        r_ptr         <= r_gnt_id + 2'd1;
                        r_state       <= ST_IDLE;
                        r_timeout_err <= w_rel_timeout;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        // Saturates so an unlimited hold never wraps the count.
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign GNT         = r_gnt;
    assign GNT_ID      = r_gnt_id;
    assign GNT_VALID   = r_gnt_valid;
    assign TIMEOUT_ERR = r_timeout_err;
    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 built with MAX_HOLD=4 so timeouts are short.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout_err;
    logic [0:0] dbg_state;
    logic [1:0] dbg_ptr;

    int total = 0;
    int bad   = 0;

    rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .REQ         (req),
        .DONE        (done),
        .GNT         (gnt),
        .GNT_ID      (gnt_id),
        .GNT_VALID   (gnt_valid),
        .TIMEOUT_ERR (timeout_err),
        .o_dbg_state (dbg_state),
        .o_dbg_ptr   (dbg_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Structural invariants checked on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (gnt_valid !== (|gnt) || ((gnt & (gnt - 4'd1)) !== 4'd0)) begin
                bad++;
                $display("FAIL invariant: gnt=%b valid=%b required one-hot/zero and valid=|gnt", gnt, gnt_valid);
            end
            if (gnt_valid === 1'b1) begin
                total++;
                if (gnt !== (4'b0001 << gnt_id)) begin
                    bad++;
                    $display("FAIL id_match: gnt=%b id=%0d", gnt, gnt_id);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #3;
        total++;
        if ({gnt, gnt_id, gnt_valid, timeout_err, dbg_state, dbg_ptr} !== 11'd0) begin
            bad++;
            $display("FAIL reset: gnt=%b id=%0d v=%b to=%b st=%b ptr=%0d required all zero",
                     gnt, gnt_id, gnt_valid, timeout_err, dbg_state, dbg_ptr);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (gnt !== 4'b0000 || dbg_state !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: gnt=%b st=%b required 0000/0", gnt, dbg_state);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        step();
        total++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1 || dbg_state !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: gnt=%b id=%0d v=%b st=%b required 0100/2/1/1",
                     gnt, gnt_id, gnt_valid, dbg_state);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || dbg_ptr !== 2'd3 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL single_release: gnt=%b v=%b ptr=%0d to=%b required 0000/0/3/0",
                     gnt, gnt_valid, dbg_ptr, timeout_err);
        end
    endtask

    task automatic test_wrap();
        req = 4'b0011;
        step();
        total++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL wrap_grant0: gnt=%b id=%0d required 0001/0", gnt, gnt_id);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (gnt !== 4'b0000 || dbg_ptr !== 2'd1) begin
            bad++;
            $display("FAIL wrap_release: gnt=%b ptr=%0d required 0000/1", gnt, dbg_ptr);
        end
        step();
        total++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL wrap_grant1: gnt=%b id=%0d required 0010/1", gnt, gnt_id);
        end
        req = 4'b0000;
        step();
        total++;
        if (gnt !== 4'b0000 || dbg_ptr !== 2'd2) begin
            bad++;
            $display("FAIL wrap_withdraw: gnt=%b ptr=%0d required 0000/2", gnt, dbg_ptr);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_id = 2'(i % 4);
            step();
            total++;
            if (gnt_id !== exp_id || gnt !== (4'b0001 << exp_id)) begin
                bad++;
                $display("FAIL fair_grant[%0d]: gnt=%b id=%0d required id=%0d", i, gnt, gnt_id, exp_id);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            total++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
                bad++;
                $display("FAIL fair_idle[%0d]: gnt=%b v=%b required 0000/0", i, gnt, gnt_valid);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        req = 4'b1000;
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gnt !== 4'b1000 || timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL to_hold[%0d]: gnt=%b to=%b required 1000/0", i, gnt, timeout_err);
            end
            step();
        end
        total++;
        if (gnt !== 4'b0000 || timeout_err !== 1'b1 || dbg_ptr !== 2'd0) begin
            bad++;
            $display("FAIL to_release: gnt=%b to=%b ptr=%0d required 0000/1/0", gnt, timeout_err, dbg_ptr);
        end
        step();
        total++;
        if (gnt !== 4'b1000 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_regrant: gnt=%b to=%b required 1000/0", gnt, timeout_err);
        end
        req = 4'b0000;
        step();
        total++;
        if (gnt !== 4'b0000 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_withdraw: gnt=%b to=%b required 0000/0", gnt, timeout_err);
        end
    endtask

    task automatic test_withdraw();
        req  = 4'b0000;
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (gnt !== 4'b0000 || dbg_state !== 1'b0 || dbg_ptr !== 2'd0) begin
            bad++;
            $display("FAIL done_in_idle: gnt=%b st=%b ptr=%0d required 0000/0/0", gnt, dbg_state, dbg_ptr);
        end
        req = 4'b0010;
        step();
        req = 4'b1011;
        step();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL no_preempt: gnt=%b required 0010", gnt);
        end
        req = 4'b1001;
        step();
        total++;
        if (gnt !== 4'b0000 || timeout_err !== 1'b0 || dbg_ptr !== 2'd2) begin
            bad++;
            $display("FAIL withdraw: gnt=%b to=%b ptr=%0d required 0000/0/2", gnt, timeout_err, dbg_ptr);
        end
        step();
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL withdraw_next: gnt=%b required 1000", gnt);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_done_at_timeout();
        req = 4'b0100;
        step();
        step();
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        total++;
        if (gnt !== 4'b0000 || timeout_err !== 1'b0 || dbg_ptr !== 2'd3) begin
            bad++;
            $display("FAIL done_vs_timeout: gnt=%b to=%b ptr=%0d required 0000/0/3", gnt, timeout_err, dbg_ptr);
        end
    endtask

    task automatic test_async_reset();
        req = 4'b0010;
        step();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL ar_pre: gnt=%b required 0010", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || dbg_ptr !== 2'd0 || dbg_state !== 1'b0) begin
            bad++;
            $display("FAIL ar_immediate: gnt=%b v=%b ptr=%0d st=%b required 0000/0/0/0",
                     gnt, gnt_valid, dbg_ptr, dbg_state);
        end
        req = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL ar_first: gnt=%b id=%0d required 0001/0", gnt, gnt_id);
        end
        req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_timeout();
        test_withdraw();
        test_done_at_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource (e.g. the 4-to-2 encoder datapath or a shared bus) among requesters 0..3.
- Issues a registered one-hot grant plus its 2-bit encoded index.
- Holds the grant until the owner signals DONE, drops its request, or exceeds a hold limit.
- After each release, rotates priority so the last owner goes to lowest priority.

Parameters:
- MAX_HOLD, 16: max cycles a grant may be held; 0 disables the timeout.
- CNT_W, 8: hold counter width; MAX_HOLD must be < 2**CNT_W.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- REQ  input  4  request lines, bit i = requester i, level-sensitive.
- DONE  input  1  owner finished; sampled only in BUSY.
- GNT  output  4  one-hot grant, registered.
- GNT_ID  output  2  encoded index of the granted requester, registered.
- GNT_VALID  output  1  high while any grant is active (equals |GNT).
- TIMEOUT_ERR  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, GNT=4'b0000, GNT_ID=2'b00, GNT_VALID=0, TIMEOUT_ERR=0.
  - Priority pointer ptr=0, hold counter cnt=0.
  - Outputs go to these values immediately, independent of clk.
- States: IDLE, BUSY.
- IDLE:
  - If REQ!=0 at a rising edge, select winner w = first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with REQ[i]=1.
  - At that edge: GNT<=1<<w, GNT_ID<=w, GNT_VALID<=1, cnt<=0, state<=BUSY.
  - Latency is 1 clock from REQ sampled high to GNT visible.
  - If REQ=0, remain in IDLE with all outputs 0.
- BUSY, owner o=GNT_ID; each edge evaluates release conditions in this priority:
  1. DONE=1 -> normal release.
  2. REQ[o]=0 -> normal release (requester withdrew).
  3. MAX_HOLD!=0 and cnt==MAX_HOLD-1 -> timeout release; TIMEOUT_ERR<=1 for exactly one cycle.
  4. Otherwise -> cnt<=cnt+1 and the grant is held.
  - Simultaneous DONE and timeout is a normal release, with no TIMEOUT_ERR.
- On any release at an edge:
  - GNT<=0, GNT_VALID<=0, GNT_ID<=0.
  - ptr<=(o+1) mod 4, state<=IDLE.
- Grants are never back-to-back: at least one IDLE cycle with GNT=0 separates consecutive grants. This guarantees a clean hand-off of the shared resource.
- No preemption: new or higher-priority requests never change an active grant.
- DONE in IDLE is ignored.
- Grant duration when MAX_HOLD=N (N>0):
  - A grant is visible for at most N cycles; the TIMEOUT_ERR pulse coincides with the first cycle GNT=0.
  - The counter never wraps.
- With MAX_HOLD=0 the counter still increments but saturates at 2**CNT_W-1, and no timeout occurs.
- Fairness: with all four REQ held high and DONE asserted each grant's first cycle, grant order is 0,1,2,3,0,...
- Reset asserted mid-grant: GNT drops immediately and ptr returns to 0. After rst_n rises, the first grant follows the IDLE rule.
- Invariants:
  - GNT is always 0 or one-hot.
  - GNT_ID matches GNT whenever GNT_VALID=1.
  - GNT_VALID==|GNT.

Test Plan:
- Reset then single request: rst_n low, then REQ=4'b0100 -> one edge later GNT=4'b0100, GNT_ID=2, GNT_VALID=1; DONE pulse -> next edge GNT=0, ptr=3.
- Round-robin fairness: REQ=4'b1111 held, DONE=1 for one cycle after each grant -> GNT_ID sequence 0,1,2,3,0, each grant followed by one idle cycle.
- Pointer wrap and skip: ptr=3 after releasing owner 2, REQ=4'b0011 -> grant goes to 0 (not 1); release -> next grant to 1.
- Timeout: MAX_HOLD=4, REQ=4'b1000 held, DONE=0 -> GNT=4'b1000 for exactly 4 cycles, then GNT=0 with TIMEOUT_ERR=1 for one cycle; next grant back to 3 after the idle cycle.
- Withdrawal and simultaneous events:
  - Owner 1 drops REQ[1] mid-grant -> release next edge, no TIMEOUT_ERR.
  - DONE=1 on the cycle cnt==MAX_HOLD-1 -> release with TIMEOUT_ERR=0.
- Async reset mid-grant: assert rst_n=0 between edges while GNT=4'b0010 -> GNT=0 and GNT_VALID=0 immediately. After release of reset with REQ=4'b1111, the first grant is 0.
